// File: rtl/i2c_request_arbiter_pkg.sv
// i2c_request_arbiter_pkg: FSM state encoding and I2C field widths shared by the arbiter files.
package i2c_request_arbiter_pkg;
    localparam int ADDR_W = 7;
    localparam int REG_W  = 8;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
endpackage

// File: rtl/i2c_request_arbiter_picker.sv
// i2c_request_arbiter_picker: combinational round-robin pick of the first request at or above ptr.
//   req   in  N   request vector
//   ptr   in  PW  highest-priority index
//   grant out N   one-hot winner
//   idx   out PW  winner index
//   valid out 1   any request present
module i2c_request_arbiter_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          valid
);
    int j;
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        // Scan from the farthest offset down so the closest one to ptr is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            j = j >= N ? j - N : j;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = PW'(j);
                valid    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_request_arbiter.sv
// i2c_request_arbiter: round-robin sharing of one i2c_controller among NUM_REQ requesters.
//   clk_i, rst_ni             clock, async active-low reset
//   req_i/addr_i/rw_i/reg_id_i/wdata_i   per-requester request and packed fields
//   grant_o/done_o/err_o/rdata_o         grant, completion pulse, timeout flag, read data
//   i2c_*_o / i2c_rdata_i / i2c_busy_i   controller command fields and handshake
module i2c_request_arbiter
    import i2c_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [ADDR_W*NUM_REQ-1:0] addr_i,
    input  logic [NUM_REQ-1:0]      rw_i,
    input  logic [REG_W*NUM_REQ-1:0]  reg_id_i,
    input  logic [DATA_W*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic                    err_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic [ADDR_W-1:0]       i2c_address_o,
    output logic                    i2c_rw_o,
    output logic [REG_W-1:0]        i2c_reg_id_o,
    output logic [DATA_W-1:0]       i2c_wdata_o,
    input  logic [DATA_W-1:0]       i2c_rdata_i,
    output logic                    i2c_execute_o,
    input  logic                    i2c_busy_i
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    state_t             state, state_n;
    logic [NUM_REQ-1:0] win_oh, grant;
    logic [PTR_W-1:0]   win_idx, sel, ptr;
    logic               win_valid, err, launch, timeout;
    logic [CNT_W-1:0]   cnt;

    i2c_request_arbiter_picker #(.N(NUM_REQ), .PW(PTR_W)) u_picker (
        .req   (req_i),
        .ptr   (ptr),
        .grant (win_oh),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign launch  = state == IDLE && win_valid && !i2c_busy_i;
    // Execute has been held START_TIMEOUT cycles without busy rising.
    assign timeout = state == LAUNCH && !i2c_busy_i && cnt == CNT_W'(START_TIMEOUT - 1);

    always_comb begin
        state_n       = state;
        i2c_execute_o = state == LAUNCH;
        grant_o       = grant;
        done_o        = state == DONE ? grant : '0;
        err_o         = state == DONE && err;
        case (state)
            IDLE:    state_n = launch ? LAUNCH : IDLE;
            LAUNCH:  state_n = i2c_busy_i ? RUN : timeout ? DONE : LAUNCH;
            RUN:     state_n = i2c_busy_i ? RUN : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            grant         <= '0;
            sel           <= '0;
            ptr           <= '0;
            cnt           <= '0;
            err           <= 1'b0;
            rdata_o       <= '0;
            i2c_address_o <= '0;
            i2c_rw_o      <= 1'b0;
            i2c_reg_id_o  <= '0;
            i2c_wdata_o   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (launch) begin
                    grant         <= win_oh;
                    sel           <= win_idx;
                    cnt           <= '0;
                    err           <= 1'b0;
                    i2c_address_o <= addr_i[ADDR_W*win_idx +: ADDR_W];
                    i2c_rw_o      <= rw_i[win_idx];
                    i2c_reg_id_o  <= reg_id_i[REG_W*win_idx +: REG_W];
                    i2c_wdata_o   <= wdata_i[DATA_W*win_idx +: DATA_W];
                end
                LAUNCH: begin
                    cnt <= cnt + 1'b1;
                    err <= timeout;
                end
                RUN: if (!i2c_busy_i && i2c_rw_o) rdata_o <= i2c_rdata_i;
                default: begin
                    grant <= '0;
                    ptr   <= sel == PTR_W'(NUM_REQ - 1) ? '0 : sel + 1'b1;
                end
            endcase
        end
    end
endmodule
